fpcmult_arbiter: RTL and testbench



---
 rtl/fpcmult_arbiter_pkg.sv | 19 +
 rtl/fpcmult_arbiter_rr_picker.sv | 34 +++
 rtl/fpcmult_arbiter.sv | 154 +++++++++++++++
 tb/tb_fpcmult_arbiter.sv | 382 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fpcmult_arbiter_pkg.sv
// fpcmult_arbiter_pkg: FSM state encoding and default widths shared by the arbiter files.
package fpcmult_arbiter_pkg;

    localparam int N_DEFAULT = 32;
    localparam int D_DEFAULT = 16;

    // IDLE grant+accept | ISSUE operands to multiplier | WAIT await product | RESP hold result
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    function automatic int idx_width(input int nreq);
        return (nreq > 1) ? $clog2(nreq) : 1;
    endfunction

endpackage

// File: rtl/fpcmult_arbiter_rr_picker.sv
// rr_picker: combinational round-robin pick of the first valid requester at or after i_ptr.
module rr_picker
    import fpcmult_arbiter_pkg::*;
#(
    parameter  int NREQ = 4,
    localparam int IW   = idx_width(NREQ)
)(
    input  logic [NREQ-1:0] i_val,
    input  logic [IW-1:0]   i_ptr,
    output logic [NREQ-1:0] o_grant,
    output logic [IW-1:0]   o_idx,
    output logic            o_any
);

    always_comb begin
        int s;
        s       = 0;
        o_grant = '0;
        o_idx   = '0;
        o_any   = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            s = int'(i_ptr) + k;
            if (s >= NREQ) begin
                s = s - NREQ;
            end
            if (!o_any && i_val[IW'(s)]) begin
                o_any              = 1'b1;
                o_idx              = IW'(s);
                o_grant[IW'(s)]    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fpcmult_arbiter.sv
// fpcmult_arbiter: serialises NREQ requesters onto one shared complex multiplier, one in flight.
// Define FPCMULT_ARBITER_ZERO_BYPASS_EN to answer zero-operand requests without the multiplier.
module fpcmult_arbiter
    import fpcmult_arbiter_pkg::*;
#(
    parameter int n    = N_DEFAULT,
    parameter int d    = D_DEFAULT,
    parameter int NREQ = 4
)(
    input  logic              clk,
    input  logic              reset,
    input  logic [NREQ-1:0]   i_req_val,
    output logic [NREQ-1:0]   o_req_rdy,
    input  logic [NREQ*n-1:0] i_req_ar,
    input  logic [NREQ*n-1:0] i_req_ac,
    input  logic [NREQ*n-1:0] i_req_br,
    input  logic [NREQ*n-1:0] i_req_bc,
    output logic [NREQ-1:0]   o_resp_val,
    input  logic [NREQ-1:0]   i_resp_rdy,
    output logic [n-1:0]      o_resp_cr,
    output logic [n-1:0]      o_resp_cc,
    output logic              o_m_recv_val,
    input  logic              i_m_recv_rdy,
    output logic [n-1:0]      o_m_ar,
    output logic [n-1:0]      o_m_ac,
    output logic [n-1:0]      o_m_br,
    output logic [n-1:0]      o_m_bc,
    input  logic              i_m_send_val,
    output logic              o_m_send_rdy,
    input  logic [n-1:0]      i_m_cr,
    input  logic [n-1:0]      i_m_cc
);

    localparam int IW = idx_width(NREQ);

    if (NREQ < 2 || NREQ > 8 || d >= n) begin : g_param_check
        $error("fpcmult_arbiter: NREQ must be 2..8 and d below n");
    end

    state_t          r_state;
    logic [IW-1:0]   r_ptr;
    logic [IW-1:0]   r_gidx;
    logic [n-1:0]    r_ar, r_ac, r_br, r_bc;
    logic [n-1:0]    r_cr, r_cc;

    logic [NREQ-1:0] w_grant;
    logic [IW-1:0]   w_idx;
    logic [IW-1:0]   w_next_ptr;
    logic            w_any;
    logic            w_zero;
    logic [n-1:0]    w_ar, w_ac, w_br, w_bc;

    rr_picker #(.NREQ(NREQ)) u_picker (
        .i_val   (i_req_val),
        .i_ptr   (r_ptr),
        .o_grant (w_grant),
        .o_idx   (w_idx),
        .o_any   (w_any)
    );

    always_comb begin
        w_ar = '0;
        w_ac = '0;
        w_br = '0;
        w_bc = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_idx == IW'(i)) begin
                w_ar = i_req_ar[i*n +: n];
                w_ac = i_req_ac[i*n +: n];
                w_br = i_req_br[i*n +: n];
                w_bc = i_req_bc[i*n +: n];
            end
        end
    end

`ifdef FPCMULT_ARBITER_ZERO_BYPASS_EN
    // A zero operand makes the product exactly zero, so the multiplier is skipped.
    assign w_zero = ((w_ar == '0) && (w_ac == '0)) || ((w_br == '0) && (w_bc == '0));
`else
    assign w_zero = 1'b0;
`endif

    assign w_next_ptr   = (r_gidx == IW'(NREQ-1)) ? '0 : r_gidx + 1'b1;

    assign o_req_rdy    = (r_state == IDLE) ? w_grant : '0;
    assign o_m_recv_val = (r_state == ISSUE);
    assign o_m_send_rdy = (r_state == WAIT);
    assign o_m_ar       = r_ar;
    assign o_m_ac       = r_ac;
    assign o_m_br       = r_br;
    assign o_m_bc       = r_bc;
    assign o_resp_cr    = r_cr;
    assign o_resp_cc    = r_cc;

    always_comb begin
        o_resp_val = '0;
        if (r_state == RESP) begin
            o_resp_val[r_gidx] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_ptr   <= '0;
            r_gidx  <= '0;
            r_ar    <= '0;
            r_ac    <= '0;
            r_br    <= '0;
            r_bc    <= '0;
            r_cr    <= '0;
            r_cc    <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_any) begin
                        r_gidx <= w_idx;
                        r_ar   <= w_ar;
                        r_ac   <= w_ac;
                        r_br   <= w_br;
                        r_bc   <= w_bc;
                        if (w_zero) begin
                            r_cr    <= '0;
                            r_cc    <= '0;
                            r_state <= RESP;
                        end else begin
                            r_state <= ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    if (i_m_recv_rdy) begin
                        r_state <= WAIT;
                    end
                end
                WAIT: begin
                    if (i_m_send_val) begin
                        r_cr    <= i_m_cr;
                        r_cc    <= i_m_cc;
                        r_state <= RESP;
                    end
                end
                RESP: begin
                    if (i_resp_rdy[r_gidx]) begin
                        r_ptr   <= w_next_ptr;
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fpcmult_arbiter.sv
// tb_fpcmult_arbiter: vector table, hand-written corner sequences and a randomized run
// checked against a transaction-level model of round-robin service.
module tb_fpcmult_arbiter;

    localparam int N  = 32;
    localparam int NR = 4;

    logic            clk;
    logic            reset;
    logic [NR-1:0]   i_req_val;
    logic [NR-1:0]   o_req_rdy;
    logic [NR*N-1:0] i_req_ar, i_req_ac, i_req_br, i_req_bc;
    logic [NR-1:0]   o_resp_val;
    logic [NR-1:0]   i_resp_rdy;
    logic [N-1:0]    o_resp_cr, o_resp_cc;
    logic            o_m_recv_val;
    logic            i_m_recv_rdy;
    logic [N-1:0]    o_m_ar, o_m_ac, o_m_br, o_m_bc;
    logic            i_m_send_val;
    logic            o_m_send_rdy;
    logic [N-1:0]    i_m_cr, i_m_cc;

    fpcmult_arbiter #(.n(N), .d(16), .NREQ(NR)) dut (
        .clk          (clk),
        .reset        (reset),
        .i_req_val    (i_req_val),
        .o_req_rdy    (o_req_rdy),
        .i_req_ar     (i_req_ar),
        .i_req_ac     (i_req_ac),
        .i_req_br     (i_req_br),
        .i_req_bc     (i_req_bc),
        .o_resp_val   (o_resp_val),
        .i_resp_rdy   (i_resp_rdy),
        .o_resp_cr    (o_resp_cr),
        .o_resp_cc    (o_resp_cc),
        .o_m_recv_val (o_m_recv_val),
        .i_m_recv_rdy (i_m_recv_rdy),
        .o_m_ar       (o_m_ar),
        .o_m_ac       (o_m_ac),
        .o_m_br       (o_m_br),
        .o_m_bc       (o_m_bc),
        .i_m_send_val (i_m_send_val),
        .o_m_send_rdy (o_m_send_rdy),
        .i_m_cr       (i_m_cr),
        .i_m_cc       (i_m_cc)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_pass  = 0;
    int n_total = 0;

    // Multiplier stub knobs: fixed delays, or random 0..3 when m_rand is set.
    int recv_dly = 0;
    int send_dly = 0;
    bit m_rand   = 1'b0;

    typedef struct {
        int          idx;
        logic [31:0] ar, ac, br, bc;
        logic [31:0] cr, cc;
    } vec_t;
    vec_t vecs[5];

    function automatic logic [63:0] cmul(input logic [31:0] ar, ac, br, bc);
        longint pr, pi;
        pr = longint'($signed(ar)) * longint'($signed(br)) - longint'($signed(ac)) * longint'($signed(bc));
        pi = longint'($signed(ar)) * longint'($signed(bc)) + longint'($signed(ac)) * longint'($signed(br));
        pr = pr >>> 16;
        pi = pi >>> 16;
        return {pr[31:0], pi[31:0]};
    endfunction

    function automatic logic [63:0] model_result(input logic [31:0] ar, ac, br, bc);
`ifdef FPCMULT_ARBITER_ZERO_BYPASS_EN
        if ((ar == 0 && ac == 0) || (br == 0 && bc == 0)) return 64'd0;
`endif
        return cmul(ar, ac, br, bc);
    endfunction

    function automatic logic [NR-1:0] onehot(input int i);
        logic [NR-1:0] r;
        r = '0;
        if (i >= 0 && i < NR) r[i] = 1'b1;
        return r;
    endfunction

    task automatic check_eq(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    endtask

    task automatic set_ops(input int idx, input logic [31:0] ar, ac, br, bc);
        i_req_ar[idx*N +: N] = ar;
        i_req_ac[idx*N +: N] = ac;
        i_req_br[idx*N +: N] = br;
        i_req_bc[idx*N +: N] = bc;
    endtask

    // Returns at the falling edge just after the accepting rising edge.
    task automatic issue_req(input string name, input int idx, input logic [31:0] ar, ac, br, bc);
        bit ok;
        @(negedge clk);
        set_ops(idx, ar, ac, br, bc);
        i_req_val      = '0;
        i_req_val[idx] = 1'b1;
        ok = 1'b0;
        for (int k = 0; k < 20; k++) begin
            #1;
            if (o_req_rdy[idx]) ok = 1'b1;
            @(negedge clk);
            if (ok) break;
        end
        i_req_val = '0;
        check_eq({name, "_accept"}, 128'(ok), 128'd1);
    endtask

    // Polls each falling edge (+1) until resp_val appears; lat = falling edges waited.
    task automatic wait_resp(input string name, output int lat);
        bit found;
        found = 1'b0;
        lat   = 0;
        for (int k = 0; k < 60; k++) begin
            #1;
            if (o_resp_val != 0) begin
                found = 1'b1;
                break;
            end
            @(negedge clk);
            lat++;
        end
        check_eq({name, "_resp_seen"}, 128'(found), 128'd1);
    endtask

    initial begin : mult_stub
        int ph, cnt;
        logic [63:0] res;
        ph = 0; cnt = 0; res = '0;
        i_m_recv_rdy = 1'b0;
        i_m_send_val = 1'b0;
        i_m_cr = '0;
        i_m_cc = '0;
        forever begin
            @(negedge clk);
            if (reset) begin
                ph = 0;
                i_m_recv_rdy = 1'b0;
                i_m_send_val = 1'b0;
            end else begin
                if (ph == 3) begin
                    i_m_send_val = 1'b0;
                    ph = 0;
                end
                if (ph == 2) begin
                    i_m_recv_rdy = 1'b0;
                    if (cnt == 0) begin
                        i_m_send_val     = 1'b1;
                        {i_m_cr, i_m_cc} = res;
                        ph = 3;
                    end else cnt--;
                end
                if (ph == 0 && o_m_recv_val) begin
                    cnt = m_rand ? int'($urandom_range(0, 3)) : recv_dly;
                    ph = 1;
                end
                if (ph == 1) begin
                    if (cnt == 0) begin
                        i_m_recv_rdy = 1'b1;
                        res = cmul(o_m_ar, o_m_ac, o_m_br, o_m_bc);
                        cnt = m_rand ? int'($urandom_range(0, 3)) : send_dly;
                        ph = 2;
                    end else cnt--;
                end
            end
        end
    end

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: time limit reached, passed %0d of %0d so far", n_pass, n_total);
        $fatal(1, "watchdog expired");
    end

    // Random-phase model state
    bit            pend[NR];
    logic [31:0]   op_ar[NR], op_ac[NR], op_br[NR], op_bc[NR];
    int            mptr, bidx, exp_i, done, lat, j;
    bit            busy;
    logic [63:0]   bexp;
    logic [NR-1:0] acc, rsp, g;

    initial begin : main
        vecs[0] = '{1, 32'h0001_0000, 32'h0, 32'h0002_0000, 32'h0, 32'h0002_0000, 32'h0};
        vecs[1] = '{0, 32'h0001_0000, 32'h0001_0000, 32'h0001_0000, 32'h0001_0000, 32'h0, 32'h0002_0000};
        vecs[2] = '{2, 32'h0001_8000, 32'h0, 32'h0, 32'h0002_0000, 32'h0, 32'h0003_0000};
        vecs[3] = '{3, 32'hFFFF_0000, 32'h0000_8000, 32'h0002_0000, 32'h0001_0000, 32'hFFFD_8000, 32'h0};
        vecs[4] = '{1, 32'h0003_0000, 32'h0002_0000, 32'h0001_0000, 32'hFFFF_0000, 32'h0005_0000, 32'hFFFF_0000};

        reset      = 1'b1;
        i_req_val  = '0;
        i_resp_rdy = '0;
        i_req_ar   = '0;
        i_req_ac   = '0;
        i_req_br   = '0;
        i_req_bc   = '0;

        // Reset state
        repeat (3) @(negedge clk);
        #1;
        check_eq("reset_outputs",
                 {o_req_rdy, o_resp_val, o_m_recv_val, o_m_send_rdy, o_resp_cr, o_resp_cc, o_m_ar},
                 128'd0);
        i_req_val = 4'b0100;
        #1;
        check_eq("reset_grant", o_req_rdy, 4'b0100);
        i_req_val = '0;
        @(negedge clk);
        reset      = 1'b0;
        i_resp_rdy = '1;

        // Vector table, single requester each, zero-latency multiplier
        for (int r = 0; r < 5; r++) begin
            issue_req($sformatf("vec%0d", r), vecs[r].idx, vecs[r].ar, vecs[r].ac, vecs[r].br, vecs[r].bc);
            wait_resp($sformatf("vec%0d", r), lat);
            check_eq($sformatf("vec%0d_resp_val", r), o_resp_val, onehot(vecs[r].idx));
            check_eq($sformatf("vec%0d_cr", r), o_resp_cr, vecs[r].cr);
            check_eq($sformatf("vec%0d_cc", r), o_resp_cc, vecs[r].cc);
            check_eq($sformatf("vec%0d_latency", r), 128'(lat), 128'd2);
            @(negedge clk);
        end

        // Round-robin order with all four requesting continuously from ptr 0
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < NR; i++) set_ops(i, $urandom, $urandom, $urandom, $urandom);
        i_req_val = '1;
        for (int t = 0; t < 8; t++) begin
            g = '0;
            for (int k = 0; k < 30; k++) begin
                #1;
                if (o_req_rdy != 0) begin
                    g = o_req_rdy;
                    @(negedge clk);
                    break;
                end
                @(negedge clk);
            end
            check_eq($sformatf("rr_order_%0d", t), g, onehot(t % NR));
        end
        i_req_val = '0;
        repeat (6) @(negedge clk);

        // Result held while resp_rdy is low; no new grants
        i_resp_rdy = '0;
        issue_req("stall", 3, vecs[3].ar, vecs[3].ac, vecs[3].br, vecs[3].bc);
        wait_resp("stall", lat);
        i_req_val = 4'b0111;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            #1;
            check_eq($sformatf("stall_hold_%0d", c),
                     {o_resp_val, o_resp_cr, o_resp_cc, o_req_rdy, o_m_recv_val},
                     {4'b1000, vecs[3].cr, vecs[3].cc, 4'b0000, 1'b0});
        end
        i_resp_rdy = 4'b1000;
        @(negedge clk);
        #1;
        check_eq("stall_release_grant", {o_resp_val, o_req_rdy}, {4'b0000, 4'b0001});
        i_req_val  = '0;
        i_resp_rdy = '1;

        // Multiplier not ready for 5 cycles: ISSUE holds operands
        recv_dly = 5;
        issue_req("issue_hold", 2, vecs[2].ar, vecs[2].ac, vecs[2].br, vecs[2].bc);
        for (int c = 0; c < 5; c++) begin
            #1;
            check_eq($sformatf("issue_hold_%0d", c),
                     {o_m_recv_val, o_m_ar, o_m_ac, o_m_br, o_m_bc},
                     {1'b1, vecs[2].ar, vecs[2].ac, vecs[2].br, vecs[2].bc});
            @(negedge clk);
        end
        recv_dly = 0;
        wait_resp("issue_hold", lat);
        check_eq("issue_hold_result", {o_resp_val, o_resp_cr, o_resp_cc},
                 {4'b0100, vecs[2].cr, vecs[2].cc});
        @(negedge clk);

        // Reset while waiting on the multiplier abandons the transaction and clears ptr
        issue_req("pre_reset", 1, vecs[0].ar, vecs[0].ac, vecs[0].br, vecs[0].bc);
        wait_resp("pre_reset", lat);
        @(negedge clk);
        send_dly = 20;
        issue_req("wait_reset", 2, vecs[4].ar, vecs[4].ac, vecs[4].br, vecs[4].bc);
        @(negedge clk);
        #1;
        check_eq("wait_reset_in_wait", {o_m_send_rdy, o_m_recv_val}, 2'b10);
        reset = 1'b1;
        @(negedge clk);
        #1;
        check_eq("wait_reset_idle", {o_resp_val, o_m_send_rdy, o_m_recv_val, o_req_rdy}, 128'd0);
        @(negedge clk);
        reset     = 1'b0;
        send_dly  = 0;
        i_req_val = '1;
        #1;
        check_eq("wait_reset_ptr0", o_req_rdy, 4'b0001);
        i_req_val = '0;
        repeat (2) @(negedge clk);

`ifdef FPCMULT_ARBITER_ZERO_BYPASS_EN
        issue_req("bypass", 0, 32'h0, 32'h0, 32'h0003_0000, 32'h0);
        #1;
        check_eq("bypass_resp", {o_resp_val, o_resp_cr, o_resp_cc, o_m_recv_val},
                 {4'b0001, 32'h0, 32'h0, 1'b0});
        @(negedge clk);
        #1;
        check_eq("bypass_no_mult", {o_m_recv_val, o_resp_val}, 5'd0);
`endif

        // Randomized traffic against the transaction-level model
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset  = 1'b0;
        m_rand = 1'b1;
        mptr = 0; busy = 1'b0; done = 0; bidx = 0; bexp = '0;
        for (int i = 0; i < NR; i++) pend[i] = 1'b0;
        for (int cyc = 0; cyc < 4000 && done < 60; cyc++) begin
            @(negedge clk);
            for (int i = 0; i < NR; i++) begin
                if (!pend[i] && $urandom_range(0, 2) == 0) begin
                    pend[i]  = 1'b1;
                    op_ar[i] = $urandom;
                    op_ac[i] = $urandom;
                    op_br[i] = $urandom;
                    op_bc[i] = $urandom;
                    if ($urandom_range(0, 7) == 0) begin
                        op_ar[i] = '0;
                        op_ac[i] = '0;
                    end
                    set_ops(i, op_ar[i], op_ac[i], op_br[i], op_bc[i]);
                end
                i_req_val[i] = pend[i];
            end
            i_resp_rdy = NR'($urandom_range(0, 15));
            #1;
            acc = o_req_rdy & i_req_val;
            if (acc != 0) begin
                exp_i = -1;
                for (int k = 0; k < NR; k++) begin
                    j = (mptr + k) % NR;
                    if (exp_i < 0 && pend[j]) exp_i = j;
                end
                check_eq("rnd_grant", {busy, acc}, {1'b0, onehot(exp_i)});
                if (exp_i >= 0) begin
                    busy = 1'b1;
                    bidx = exp_i;
                    bexp = model_result(op_ar[exp_i], op_ac[exp_i], op_br[exp_i], op_bc[exp_i]);
                    pend[exp_i] = 1'b0;
                end
            end
            rsp = o_resp_val & i_resp_rdy;
            if (rsp != 0) begin
                check_eq("rnd_resp", {busy, rsp, o_resp_cr, o_resp_cc}, {1'b1, onehot(bidx), bexp});
                busy = 1'b0;
                mptr = (bidx + 1) % NR;
                done++;
            end
        end
        check_eq("rnd_progress", 128'(done >= 60), 128'd1);
        m_rand    = 1'b0;
        i_req_val = '0;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
